// File: rtl/leaf_user_pkg.sv
// -----------------------------------------------------------------------------
// leaf_user_pkg
// Shared definitions for the leaf user-side stream adapters.
//   state_e        : two-state grant FSM encoding (IDLE, GRANT)
//   SKID_DEPTH     : entries in the user-side output buffer
//   SKID_CNT_BITS  : width of the buffer occupancy count (0..SKID_DEPTH)
// -----------------------------------------------------------------------------
package leaf_user_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int SKID_DEPTH    = 2;
  localparam int SKID_CNT_BITS = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/leaf_user_skid2.sv
// -----------------------------------------------------------------------------
// leaf_user_skid2
// Two-entry FIFO with 1-bit read/write pointers and an occupancy count.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   push_i  : write data_i (ignored when full)
//   data_i  : entry to write
//   pop_i   : drop the head entry (ignored when empty)
//   data_o  : head entry
//   cnt_o   : occupancy, 0..2
// -----------------------------------------------------------------------------
module leaf_user_skid2
  import leaf_user_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [SKID_CNT_BITS-1:0] cnt_o
);

  logic [WIDTH-1:0]         mem_q [SKID_DEPTH];
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [SKID_CNT_BITS-1:0] cnt_q;
  logic                     do_push;
  logic                     do_pop;

  assign do_pop  = pop_i  && (cnt_q != '0);
  assign do_push = push_i && (cnt_q != SKID_CNT_BITS'(SKID_DEPTH));

  // NOTE: the two storage entries are reset too, so the head reads zero
  // out of reset instead of X; at this depth the cost is negligible.
  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what makes a same-cycle push and pop behave correctly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the count alone.
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + SKID_CNT_BITS'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - SKID_CNT_BITS'(1);
      end
    end
  end

  assign data_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/leaf_user_rr_merge.sv
// -----------------------------------------------------------------------------
// leaf_user_rr_merge
// Burst-granular round-robin merge of NUM_IN vld/ack streams into one tagged
// output stream through a 2-entry buffer.
//   clk_user  : user clock, rising edge
//   reset     : asynchronous active-high reset
//   din_user  : NUM_IN packed words, port 0 in the LSBs
//   vld_in    : per-port valid
//   ack_in    : per-port accept (registered-state only, no path from ack_out)
//   dout_user : head word of the output buffer
//   src_out   : zero-based port index that supplied dout_user
//   vld_out   : output valid
//   ack_out   : downstream accept
// -----------------------------------------------------------------------------
module leaf_user_rr_merge
  import leaf_user_pkg::*;
#(
  parameter int NUM_IN       = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int BURST_LEN    = 16,
  parameter int SRC_BITS     = $clog2(NUM_IN)
) (
  input  logic                           clk_user,
  input  logic                           reset,
  input  logic [NUM_IN*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_IN-1:0]              vld_in,
  output logic [NUM_IN-1:0]              ack_in,
  output logic [PAYLOAD_BITS-1:0]        dout_user,
  output logic [SRC_BITS-1:0]            src_out,
  output logic                           vld_out,
  input  logic                           ack_out
);

  localparam int BEAT_BITS  = $clog2(BURST_LEN);
  localparam int ENTRY_BITS = SRC_BITS + PAYLOAD_BITS;

  state_e                   state_q, state_d;
  logic [SRC_BITS-1:0]      grant_q, grant_d;
  logic [SRC_BITS-1:0]      last_grant_q, last_grant_d;
  logic [BEAT_BITS-1:0]     beat_cnt_q, beat_cnt_d;

  logic [SKID_CNT_BITS-1:0] buf_cnt;
  logic                     buf_full;
  logic                     grant_vld;
  logic [PAYLOAD_BITS-1:0]  grant_word;
  logic [SRC_BITS-1:0]      rr_pick;
  logic                     rr_found;
  logic                     push;
  logic                     pop;
  logic [ENTRY_BITS-1:0]    head;

  assign buf_full = (buf_cnt == SKID_CNT_BITS'(SKID_DEPTH));

  // Round-robin search: offsets 1..NUM_IN from last_grant, wrapping, so the
  // last granted port is considered only after every other port.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NUM_IN; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (!rr_found && vld_in[j] &&
            (((int'(last_grant_q) + i) % NUM_IN) == j)) begin
          rr_found = 1'b1;
          rr_pick  = SRC_BITS'(j);
        end
      end
    end
  end

  // Select the granted port's valid/word and drive its accept. ack_in is a
  // function of state_q, grant_q and buf_cnt only.
  always_comb begin
    grant_vld  = 1'b0;
    grant_word = '0;
    ack_in     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q == SRC_BITS'(i)) begin
        grant_vld  = vld_in[i];
        grant_word = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        ack_in[i]  = (state_q == GRANT) && !buf_full;
      end
    end
  end

  assign push = (state_q == GRANT) && grant_vld && !buf_full;
  assign pop  = vld_out && ack_out;

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d    = rr_pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!grant_vld) begin
          // Idle release: the granted source paused, give others a turn.
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (push) begin
          beat_cnt_d = beat_cnt_q + BEAT_BITS'(1);
          if (beat_cnt_q == BEAT_BITS'(BURST_LEN - 1)) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
        // Valid but buffer full: hold grant and beat count.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_BITS'(NUM_IN - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  leaf_user_skid2 #(
    .WIDTH (ENTRY_BITS)
  ) u_skid (
    .clk_i  (clk_user),
    .rst_i  (reset),
    .push_i (push),
    .data_i ({grant_q, grant_word}),
    .pop_i  (pop),
    .data_o (head),
    .cnt_o  (buf_cnt)
  );

  assign vld_out              = (buf_cnt != '0);
  assign {src_out, dout_user} = head;

endmodule

// File: tb/tb_leaf_user_rr_merge.sv
// -----------------------------------------------------------------------------
// tb_leaf_user_rr_merge
// Self-checking bench: table-driven arbitration vectors, hand-written
// reset / stream / contention / backpressure sequences, and a randomized
// run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_leaf_user_rr_merge;

  localparam int N  = 4;
  localparam int PB = 32;
  localparam int BL = 16;
  localparam int SB = 2;
  localparam int EB = SB + PB;

  logic            clk_user = 1'b0;
  logic            reset    = 1'b1;
  logic [N*PB-1:0] din_user = '0;
  logic [N-1:0]    vld_in   = '0;
  logic [N-1:0]    ack_in;
  logic [PB-1:0]   dout_user;
  logic [SB-1:0]   src_out;
  logic            vld_out;
  logic            ack_out  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_user = ~clk_user;

  leaf_user_rr_merge #(
    .NUM_IN       (N),
    .PAYLOAD_BITS (PB),
    .BURST_LEN    (BL),
    .SRC_BITS     (SB)
  ) dut (
    .clk_user  (clk_user),
    .reset     (reset),
    .din_user  (din_user),
    .vld_in    (vld_in),
    .ack_in    (ack_in),
    .dout_user (dout_user),
    .src_out   (src_out),
    .vld_out   (vld_out),
    .ack_out   (ack_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int p);
    logic [N-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Reset asserted and released away from the clock edge; returns at a drive
  // point (1 time unit after a rising edge) with all inputs idle.
  task automatic do_reset();
    vld_in   = '0;
    din_user = '0;
    ack_out  = 1'b0;
    @(posedge clk_user); #3 reset = 1'b1;
    @(posedge clk_user);
    @(posedge clk_user); #3 reset = 1'b0;
    @(posedge clk_user); #1;
  endtask

  // Offer 'mask', expect port exp_port to be acked first, then one word out.
  task automatic expect_grant(input string name, input logic [N-1:0] mask,
                              input int exp_port, input logic [PB-1:0] tag);
    for (int p = 0; p < N; p++) din_user[p*PB +: PB] = tag | PB'(p);
    vld_in  = mask;
    ack_out = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_user);
      if (ack_in != '0) break;
    end
    check({name, "_ack"}, 64'(ack_in), 64'(oh(exp_port)));
    @(posedge clk_user); #1;
    vld_in = '0;
    @(negedge clk_user);
    check({name, "_out"}, 64'({vld_out, src_out, dout_user}),
          64'({1'b1, SB'(exp_port), tag | PB'(exp_port)}));
    repeat (3) @(posedge clk_user);
    #1;
  endtask

  // One port streams n (< BL) words with ack_out high: one arbitration cycle,
  // acks on cycles 1..n, word k out on cycle k+2 with no bubbles, then idle
  // release and return to IDLE.
  task automatic stream(input string name, input int port, input int n, input logic [PB-1:0] base);
    int acc;
    logic a;
    acc = 0;
    din_user[port*PB +: PB] = base;
    vld_in  = oh(port);
    ack_out = 1'b1;
    for (int cyc = 0; cyc <= n + 2; cyc++) begin
      @(negedge clk_user);
      if (cyc == 0) check({name, "_arb"}, 64'(ack_in), 64'(0));
      if (cyc >= 1 && cyc <= n + 1) check({name, "_ack"}, 64'(ack_in), 64'(oh(port)));
      if (cyc >= 2 && cyc <= n + 1)
        check({name, "_out"}, 64'({vld_out, src_out, dout_user}),
              64'({1'b1, SB'(port), base + PB'(cyc - 2)}));
      if (cyc == n + 2) check({name, "_idle"}, 64'({ack_in, vld_out}), 64'(0));
      a = vld_in[port] && ack_in[port];
      @(posedge clk_user); #1;
      if (a) begin
        acc++;
        if (acc == n) vld_in = '0;
        else din_user[port*PB +: PB] = base + PB'(acc);
      end
    end
  endtask

  task automatic contention();
    int seq[N];
    int exp_seq[N];
    int acc_cyc[$];
    logic [EB-1:0] outs[$];
    logic [EB-1:0] w;
    int e_src, e_dat, e_gap, es;
    logic [N-1:0] acc;
    e_src = 0; e_dat = 0; e_gap = 0;
    do_reset();
    ack_out = 1'b1;
    for (int p = 0; p < N; p++) begin
      seq[p] = 0;
      exp_seq[p] = 0;
      din_user[p*PB +: PB] = {16'(p), 16'(0)};
    end
    vld_in = '1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk_user);
      acc = vld_in & ack_in;
      if (acc != '0) acc_cyc.push_back(cyc);
      if (vld_out && ack_out) outs.push_back({src_out, dout_user});
      @(posedge clk_user); #1;
      for (int p = 0; p < N; p++) begin
        if (acc[p]) begin
          seq[p]++;
          din_user[p*PB +: PB] = {16'(p), 16'(seq[p])};
        end
      end
    end
    vld_in = '0;
    check("cont_count", 64'(outs.size() >= 80), 64'(1));
    for (int j = 0; j < 80 && j < outs.size(); j++) begin
      w  = outs[j];
      es = (j / BL) % N;
      if (w[EB-1:PB] != SB'(es)) e_src++;
      if (w[PB-1:0] != {16'(es), 16'(exp_seq[es])}) e_dat++;
      exp_seq[es]++;
    end
    for (int j = 0; j < 79 && j + 1 < acc_cyc.size(); j++) begin
      if (acc_cyc[j+1] - acc_cyc[j] != (((j % BL) == BL - 1) ? 2 : 1)) e_gap++;
    end
    check("cont_src_order", 64'(e_src), 64'(0));
    check("cont_data", 64'(e_dat), 64'(0));
    check("cont_gap", 64'(e_gap), 64'(0));
    repeat (4) @(posedge clk_user);
    #1;
  endtask

  task automatic backpressure();
    int acc;
    int bad;
    logic a;
    logic [EB-1:0] outs[$];
    acc = 0; bad = 0;
    do_reset();
    din_user[0 +: PB] = 32'hB000_0000;
    vld_in = 4'b0001;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 10) ack_out = 1'b1;
      @(negedge clk_user);
      if (cyc == 9) begin
        check("bp_acc", 64'(acc), 64'(2));
        check("bp_ack", 64'(ack_in), 64'(0));
        check("bp_head", 64'({vld_out, src_out, dout_user}), 64'({1'b1, 2'd0, 32'hB000_0000}));
      end
      a = vld_in[0] && ack_in[0];
      if (vld_out && ack_out) outs.push_back({src_out, dout_user});
      @(posedge clk_user); #1;
      if (a) begin
        acc++;
        if (acc == 20) vld_in = '0;
        else din_user[0 +: PB] = 32'hB000_0000 + PB'(acc);
      end
    end
    check("bp_total", 64'(outs.size()), 64'(20));
    foreach (outs[k]) if (outs[k] != {2'd0, 32'hB000_0000 + PB'(k)}) bad++;
    check("bp_order", 64'(bad), 64'(0));
  endtask

  // Randomized run against a reference model: a queue for the buffer and a
  // few integers for who holds the grant and how many beats it has used.
  task automatic random_run();
    bit m_busy;
    int m_port, m_beats, m_last, sz, vld_pct, ack_pct;
    logic [EB-1:0] m_buf[$];
    logic [N-1:0] exp_ack, acc;
    int vp[4] = '{30, 90, 60, 100};
    int ap[4] = '{90, 30, 60, 100};
    do_reset();
    m_busy = 1'b0; m_port = 0; m_beats = 0; m_last = N - 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      vld_pct = vp[cyc / 500];
      ack_pct = ap[cyc / 500];
      @(negedge clk_user);
      sz = m_buf.size();
      exp_ack = (m_busy && sz < 2) ? oh(m_port) : '0;
      check("rnd_ack", 64'(ack_in), 64'(exp_ack));
      check("rnd_vld", 64'(vld_out), 64'(sz != 0));
      if (sz != 0) check("rnd_head", 64'({src_out, dout_user}), 64'(m_buf[0]));
      acc = vld_in & ack_in;
      if (sz != 0 && ack_out) void'(m_buf.pop_front());
      if (!m_busy) begin
        for (int i = 1; i <= N; i++) begin
          if (vld_in[(m_last + i) % N]) begin
            m_port  = (m_last + i) % N;
            m_busy  = 1'b1;
            m_beats = 0;
            break;
          end
        end
      end else if (!vld_in[m_port]) begin
        m_last = m_port;
        m_busy = 1'b0;
      end else if (sz < 2) begin
        m_buf.push_back({SB'(m_port), din_user[m_port*PB +: PB]});
        m_beats++;
        if (m_beats == BL) begin
          m_last = m_port;
          m_busy = 1'b0;
        end
      end
      if (n_fail > 40) break;
      @(posedge clk_user); #1;
      ack_out = ($urandom_range(0, 99) < ack_pct);
      for (int p = 0; p < N; p++) begin
        if (!vld_in[p] || acc[p]) begin
          vld_in[p] = ($urandom_range(0, 99) < vld_pct);
          din_user[p*PB +: PB] = $urandom;
        end
      end
    end
    vld_in = '0;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           port;
  } arb_vec_t;

  arb_vec_t arb_tbl[8];

  initial begin
    arb_tbl = '{
      '{4'b0010, 1},  // last=3, only port 1 requests: wrap and skip port 0
      '{4'b1001, 3},  // last=1: port 3 before port 0
      '{4'b1001, 0},  // last=3: wrap to port 0
      '{4'b1111, 1},
      '{4'b0001, 0},
      '{4'b0100, 2},
      '{4'b0011, 0},  // last=2: skip 3, wrap to 0
      '{4'b1110, 1}
    };

    // Reset: fill the buffer, then assert reset mid-cycle.
    do_reset();
    check("rst_vals", 64'({ack_in, vld_out, src_out, dout_user}), 64'(0));
    din_user[0 +: PB] = 32'hDEAD_0001;
    vld_in = 4'b0001;
    repeat (5) @(posedge clk_user);
    @(negedge clk_user);
    check("rst_pre_full", 64'({vld_out, ack_in}), 64'({1'b1, 4'b0000}));
    @(posedge clk_user); #3 reset = 1'b1;
    #1;
    check("rst_async_ack", 64'(ack_in), 64'(0));
    check("rst_async_vld", 64'(vld_out), 64'(0));
    check("rst_async_dout", 64'({src_out, dout_user}), 64'(0));
    @(posedge clk_user); #3 reset = 1'b0;
    @(posedge clk_user); #1;
    expect_grant("rst_first", 4'b1111, 0, 32'hC000_0000);

    // Arbitration table from a fresh reset.
    do_reset();
    for (int i = 0; i < 8; i++)
      expect_grant($sformatf("arb%0d", i), arb_tbl[i].mask, arb_tbl[i].port,
                   32'hA000_0000 | PB'(i << 8));

    do_reset();
    stream("single", 2, 5, 32'h0000_0010);
    do_reset();
    stream("pushpop", 1, 12, 32'h5500_0000);

    contention();
    backpressure();
    random_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
